// File: rtl/uart_load_ctrl_if.sv
// Byte-stream and memory-write bundle between the UART receiver,
// the load controller and the data-memory user port.
interface uart_load_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [127:0]      mem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_load_ctrl.sv
// Assembles UART bytes into 128-bit words, writes them to data memory,
// then releases the CPU pipeline once the whole image is loaded.
module uart_load_ctrl #(
    parameter int WORDS   = 4,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    uart_load_ctrl_if.master  bus,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
    localparam logic [15:0]       GAP_MAX   = 16'(TIMEOUT);

    state_e            state_q, state_d;
    logic [3:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [127:0]      data_q, data_d;
    logic [15:0]       gap_q, gap_d;
    logic              terr_q, terr_d;

    logic              accept;
    logic [15:0]       gap_inc;
    logic              go_idle;
    logic              new_sess;

    assign accept  = (state_q == COLLECT) && bus.rx_valid;
    assign gap_inc = gap_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        word_d   = word_q;
        addr_d   = addr_q;
        data_d   = data_q;
        gap_d    = gap_q;
        terr_d   = terr_q;
        go_idle  = 1'b0;
        new_sess = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    new_sess = 1'b1;
                end
            end
            COLLECT: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (accept) begin
                    data_d[{byte_q, 3'b000} +: 8] = bus.rx_data;
                    byte_d = byte_q + 4'd1;
                    gap_d  = 16'd0;
                    if (byte_q == 4'hF) begin
                        state_d = WRITE;
                        addr_d  = word_q;
                    end
                end else if (byte_q != 4'd0) begin
                    // Stalled mid-word: give up once the gap hits the limit
                    if (gap_inc == GAP_MAX) begin
                        terr_d  = 1'b1;
                        go_idle = 1'b1;
                    end else begin
                        gap_d = gap_inc;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (word_q == LAST_WORD) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                    word_d  = word_q + ADDR_W'(1);
                    data_d  = '0;
                    gap_d   = 16'd0;
                end
            end
            DONE: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (start) begin
                    new_sess = 1'b1;
                end
            end
        endcase

        if (go_idle || new_sess) begin
            state_d = go_idle ? IDLE : COLLECT;
            byte_d  = 4'd0;
            word_d  = '0;
            data_d  = '0;
            gap_d   = 16'd0;
        end
        if (new_sess) begin
            terr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            byte_q  <= 4'd0;
            word_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gap_q   <= 16'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            terr_q  <= terr_d;
        end
    end

    // abort suppresses the strobe of a WRITE cycle it lands on
    assign bus.rx_ready  = (state_q == COLLECT);
    assign bus.mem_we    = (state_q == WRITE) && !abort;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;

    assign cpu_run     = (state_q == DONE);
    assign done        = (state_q == DONE);
    assign busy        = (state_q == COLLECT) || (state_q == WRITE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Scoreboard bench for uart_load_ctrl: expected memory writes are queued
// by the stimulus and popped by a monitor on every mem_we.
module tb_uart_load_ctrl;

    localparam int AW = 16;

    localparam logic [127:0] W0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] W1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [127:0] WA = 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0;
    localparam logic [127:0] W4 = 128'h4F4E4D4C_4B4A4948_47464544_43424140;
    localparam logic [127:0] W5 = 128'h5F5E5D5C_5B5A5958_57565554_53525150;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic cpu_run;
    logic busy;
    logic done;
    logic timeout_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    wr_t  exp_q[$];

    uart_load_ctrl_if #(.ADDR_W(AW)) bus ();

    uart_load_ctrl #(
        .WORDS  (2),
        .ADDR_W (AW),
        .TIMEOUT(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 128'(bus.mem_we), 128'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 128'(bus.mem_addr), 128'(e.addr));
                check("wr_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [127:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rx_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_accept: byte %h never accepted", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 128'(bus.rx_ready), 128'd0);
        check("rst_mem_we", 128'(bus.mem_we), 128'd0);
        check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check("rst_mem_wdata", bus.mem_wdata, 128'd0);
        check("rst_flags", 128'({cpu_run, busy, done, timeout_err}), 128'd0);

        // Start on the very first edge after reset release
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 128'(busy), 128'd1);
        check("start_cpu_run", 128'(cpu_run), 128'd0);

        push_wr(16'd0, W0);
        push_wr(16'd1, W1);
        for (int k = 0; k < 16; k++) send_byte(8'(k));
        @(negedge clk);
        check("lat_mem_we", 128'(bus.mem_we), 128'd1);
        check("lat_rx_ready", 128'(bus.rx_ready), 128'd0);
        for (int k = 16; k < 32; k++) send_byte(8'(k));
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("done_done", 128'(done), 128'd1);
        check("done_cpu_run", 128'(cpu_run), 128'd1);
        check("done_busy", 128'(busy), 128'd0);
        check("done_rx_ready", 128'(bus.rx_ready), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 128'(done), 128'd1);

        // Restart from DONE
        pulse_start();
        check("restart_cpu_run", 128'(cpu_run), 128'd0);
        check("restart_busy", 128'(busy), 128'd1);
        push_wr(16'd0, WA);
        for (int k = 0; k < 16; k++) send_byte(8'hA0 + 8'(k));
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("word1_busy", 128'(busy), 128'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_rx_ready", 128'(bus.rx_ready), 128'd0);

        // Byte-gap timeout
        pulse_start();
        for (int k = 0; k < 5; k++) send_byte(8'h11 + 8'(k));
        bus.rx_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("gap9_terr", 128'(timeout_err), 128'd0);
        check("gap9_busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        check("gap10_terr", 128'(timeout_err), 128'd1);
        check("gap10_busy", 128'(busy), 128'd0);
        check("gap10_wdata", bus.mem_wdata, 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check("terr_sticky", 128'(timeout_err), 128'd1);
        pulse_start();
        check("terr_clear", 128'(timeout_err), 128'd0);

        // Abort on the byte-15 acceptance edge
        for (int k = 0; k < 15; k++) send_byte(8'h60 + 8'(k));
        bus.rx_data = 8'h6F;
        abort       = 1'b1;
        @(posedge clk);
        #1;
        abort        = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("ab15_mem_we", 128'(bus.mem_we), 128'd0);
        check("ab15_busy", 128'(busy), 128'd0);
        check("ab15_cpu_run", 128'(cpu_run), 128'd0);

        // Asynchronous reset mid-word, then a full reload
        @(posedge clk);
        #1;
        pulse_start();
        for (int k = 0; k < 3; k++) send_byte(8'h70 + 8'(k));
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_rx_ready", 128'(bus.rx_ready), 128'd0);
        check("arst_wdata", bus.mem_wdata, 128'd0);
        check("arst_addr", 128'(bus.mem_addr), 128'd0);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_wr(16'd0, W4);
        push_wr(16'd1, W5);
        for (int k = 0; k < 32; k++) send_byte(8'h40 + 8'(k));
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reload_done", 128'(done), 128'd1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_pending", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_load_ctrl.md
UART_LOAD_CTRL -- requirements
Module: uart_load_ctrl

Interface
REQ-001 Parameter WORDS, default 4, number of 128-bit words loaded per session (1..2^ADDR_W).
REQ-002 Parameter ADDR_W, default 16, word-address width of the data-memory user port.
REQ-003 Parameter TIMEOUT, default 65535, maximum idle cycles between bytes inside a partial word (1..65535).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse beginning a load session.
REQ-007 abort  in  1  level; cancels any session in progress.
REQ-008 rx_valid  in  1  UART receiver has a byte on rx_data.
REQ-009 rx_data  in  8  received byte.
REQ-010 rx_ready  out  1  controller accepts a byte this cycle.
REQ-011 mem_we  out  1  write strobe to the data-memory user port (uart_en).
REQ-012 mem_addr  out  ADDR_W  word address for the write.
REQ-013 mem_wdata  out  128  assembled word (uart_Value_in).
REQ-014 cpu_run  out  1  1 releases the pipeline; 0 holds it in reset.
REQ-015 busy  out  1  session in progress.
REQ-016 done  out  1  all WORDS words written.
REQ-017 timeout_err  out  1  sticky; set on byte-gap timeout.

Function
REQ-018 FSM states: IDLE, COLLECT, WRITE, DONE.
REQ-019 IDLE: rx_ready=0, mem_we=0, busy=0, done=0, cpu_run=0; start -> COLLECT with byte index=0, word index=0, timeout_err cleared.
REQ-020 COLLECT: rx_ready=1, busy=1, cpu_run=0; a byte is accepted only when rx_valid and rx_ready are both 1 on the same edge.
REQ-021 Byte k (k=0..15) of a word is stored little-endian at mem_wdata[8k+7:8k]; unwritten bytes of the word hold 0.
REQ-022 Acceptance of byte 15 -> WRITE on the next edge; the byte index wraps to 0.
REQ-023 WRITE: exactly one cycle; mem_we=1, mem_addr=word index, mem_wdata=complete word, rx_ready=0 (rx_valid is ignored).
REQ-024 WRITE exit: if word index=WORDS-1 -> DONE, else increment word index and go to COLLECT with the assembly register cleared to 0.
REQ-025 Latency: mem_we asserts on the cycle after the edge that accepts byte 15.
REQ-026 DONE: done=1, cpu_run=1, busy=0, rx_ready=0; remains until start or abort.
REQ-027 start in DONE: return to COLLECT (new session), cpu_run drops to 0 the same cycle the state changes.
REQ-028 start in COLLECT or WRITE: ignored.
REQ-029 abort in COLLECT, WRITE or DONE -> IDLE next edge; takes priority over start, byte acceptance and the WRITE strobe (no mem_we on that cycle's transition; the pending byte is discarded).
REQ-030 Gap counter: cleared on each accepted byte and on entry to COLLECT; increments each COLLECT cycle while byte index is not 0.
REQ-031 When the gap counter reaches TIMEOUT: set timeout_err, discard the partial word, go to IDLE; no timeout is applied while byte index=0.
REQ-032 mem_addr holds its last value outside WRITE; mem_we=1 only in WRITE.

Reset
REQ-033 rst=0 asynchronously forces IDLE; rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, done=0, timeout_err=0, all counters 0.
REQ-034 Reset mid-session discards the partial word; no write is issued after release.
REQ-035 After rst rises, the first start is honoured on the first rising edge that samples it.

Verification
REQ-036 WORDS=2, start, bytes 0x00..0x1F streamed back to back -> mem_we at addr 0 with data 0x0F0E..0100, then at addr 1 with 0x1F1E..1110; then done=1, cpu_run=1.
REQ-037 rx_valid held high during WRITE -> no byte is lost or duplicated; word 1 byte 0 is accepted only in COLLECT.
REQ-038 TIMEOUT=10, 5 bytes then silence -> timeout_err=1 after 10 cycles, state IDLE, no mem_we.
REQ-039 abort asserted on the byte-15 acceptance edge -> IDLE, no mem_we, cpu_run=0.
REQ-040 rst pulsed low mid-word asynchronously (between edges) -> all outputs go to reset values immediately; a new start reloads from addr 0.
REQ-041 start in DONE -> cpu_run=0, busy=1, and the next word written is at addr 0.
